// File: rtl/craft_mover_if.sv
// Control and position bundle between the craft input source and craft_mover.
// master drives movement requests; slave (the mover) returns position and edge flags.
interface craft_mover_if #(
   parameter int unsigned X_W = 10,
   parameter int unsigned Y_W = 10
);
   logic           move_en_i;
   logic [3:0]     dir_i;
   logic           respawn_i;
   logic [X_W-1:0] x_pos_o;
   logic [Y_W-1:0] y_pos_o;
   logic           moving_o;
   logic [3:0]     at_edge_o;

   modport master (
      output move_en_i, dir_i, respawn_i,
      input  x_pos_o, y_pos_o, moving_o, at_edge_o
   );

   modport slave (
      input  move_en_i, dir_i, respawn_i,
      output x_pos_o, y_pos_o, moving_o, at_edge_o
   );
endinterface

// File: rtl/craft_mover.sv
// Clamped, prescaled position engine for the player craft.
// Optional CRAFT_MOVER_ACCEL_EN doubles the step after a sustained identical direction.
module craft_mover #(
   parameter int unsigned X_W        = 10,
   parameter int unsigned Y_W        = 10,
   parameter int unsigned H_DISP     = 640,
   parameter int unsigned V_DISP     = 480,
   parameter int unsigned OBJ_X_SIZE = 32,
   parameter int unsigned OBJ_Y_SIZE = 32,
   parameter int unsigned MARGIN     = 2,
   parameter int unsigned STEP       = 2,
   parameter int unsigned TICK_DIV   = 2,
   parameter int unsigned DEF_X      = 304,
   parameter int unsigned DEF_Y      = 400
) (
   input logic          clk,
   input logic          rst,
   craft_mover_if.slave bus
);

   localparam int unsigned X_MIN = MARGIN;
   localparam int unsigned X_MAX = H_DISP - OBJ_X_SIZE - MARGIN;
   localparam int unsigned Y_MIN = MARGIN;
   localparam int unsigned Y_MAX = V_DISP - OBJ_Y_SIZE - MARGIN;
   localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [X_W:0] XMIN_E = (X_W+1)'(X_MIN);
   localparam logic [X_W:0] XMAX_E = (X_W+1)'(X_MAX);
   localparam logic [Y_W:0] YMIN_E = (Y_W+1)'(Y_MIN);
   localparam logic [Y_W:0] YMAX_E = (Y_W+1)'(Y_MAX);
   localparam logic [3:0] DEF_EDGE = {DEF_Y == Y_MIN, DEF_Y == Y_MAX,
                                      DEF_X == X_MIN, DEF_X == X_MAX};

   logic [X_W-1:0] x_q;
   logic [Y_W-1:0] y_q;
   logic           moving_q;
   logic [3:0]     edge_q;
   logic [PW-1:0]  presc_q;

   logic [X_W:0]   x_e, x_step, x_n;
   logic [Y_W:0]   y_e, y_step, y_n;
   logic           step_fire;

`ifdef CRAFT_MOVER_ACCEL_EN
   logic [1:0] hold_q;
   logic [3:0] last_dir_q;
`endif

   assign step_fire = bus.move_en_i && (presc_q == PW'(TICK_DIV - 1));

   always_comb begin
      x_step = (X_W+1)'(STEP);
      y_step = (Y_W+1)'(STEP);
`ifdef CRAFT_MOVER_ACCEL_EN
      if (hold_q == 2'd3) begin
         x_step = (X_W+1)'(2 * STEP);
         y_step = (Y_W+1)'(2 * STEP);
      end
`endif
      x_e = {1'b0, x_q};
      y_e = {1'b0, y_q};
      x_n = x_e;
      y_n = y_e;
      // Left decrements x; right increments; both or neither cancel.
      if (bus.dir_i[1] && !bus.dir_i[0]) begin
         x_n = (x_e < XMIN_E + x_step) ? XMIN_E : x_e - x_step;
      end else if (bus.dir_i[0] && !bus.dir_i[1]) begin
         x_n = (x_e + x_step > XMAX_E) ? XMAX_E : x_e + x_step;
      end
      if (bus.dir_i[3] && !bus.dir_i[2]) begin
         y_n = (y_e < YMIN_E + y_step) ? YMIN_E : y_e - y_step;
      end else if (bus.dir_i[2] && !bus.dir_i[3]) begin
         y_n = (y_e + y_step > YMAX_E) ? YMAX_E : y_e + y_step;
      end
      // Pulls out-of-range defaults into bounds on the first applied step.
      if (x_n > XMAX_E) x_n = XMAX_E;
      if (x_n < XMIN_E) x_n = XMIN_E;
      if (y_n > YMAX_E) y_n = YMAX_E;
      if (y_n < YMIN_E) y_n = YMIN_E;
   end

   always_ff @(posedge clk) begin
      if (rst || bus.respawn_i) begin
         x_q      <= X_W'(DEF_X);
         y_q      <= Y_W'(DEF_Y);
         moving_q <= 1'b0;
         edge_q   <= DEF_EDGE;
         presc_q  <= '0;
`ifdef CRAFT_MOVER_ACCEL_EN
         hold_q     <= '0;
         last_dir_q <= '0;
`endif
      end else if (bus.move_en_i) begin
         if (step_fire) begin
            presc_q  <= '0;
            x_q      <= x_n[X_W-1:0];
            y_q      <= y_n[Y_W-1:0];
            moving_q <= (x_n != x_e) || (y_n != y_e);
            edge_q   <= {y_n == YMIN_E, y_n == YMAX_E, x_n == XMIN_E, x_n == XMAX_E};
`ifdef CRAFT_MOVER_ACCEL_EN
            last_dir_q <= bus.dir_i;
            if (bus.dir_i == 4'd0) begin
               hold_q <= '0;
            end else if (bus.dir_i != last_dir_q) begin
               hold_q <= 2'd1;
            end else if (hold_q != 2'd3) begin
               hold_q <= hold_q + 2'd1;
            end
`endif
         end else begin
            presc_q <= presc_q + PW'(1);
         end
      end
   end

   assign bus.x_pos_o   = x_q;
   assign bus.y_pos_o   = y_q;
   assign bus.moving_o  = moving_q;
   assign bus.at_edge_o = edge_q;

endmodule

// File: tb/tb_craft_mover.sv
// Directed self-checking bench for craft_mover (default parameters, TICK_DIV=2).
// With CRAFT_MOVER_ACCEL_EN a second TICK_DIV=1 instance exercises acceleration.
module tb_craft_mover;
   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   craft_mover_if #(.X_W(10), .Y_W(10)) bus ();

   craft_mover dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

`ifdef CRAFT_MOVER_ACCEL_EN
   craft_mover_if #(.X_W(10), .Y_W(10)) abus ();

   craft_mover #(.TICK_DIV(1), .DEF_Y(300)) dut_acc (
      .clk (clk),
      .rst (rst),
      .bus (abus.slave)
   );
`endif

   task automatic check(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_pos(input string tag, input int ex, input int ey, input int emv,
                            input int eedge);
      check({tag, " x"}, int'(bus.x_pos_o), ex);
      check({tag, " y"}, int'(bus.y_pos_o), ey);
      check({tag, " moving"}, int'(bus.moving_o), emv);
      check({tag, " edge"}, int'(bus.at_edge_o), eedge);
   endtask

   // One move_en_i strobe; returns at the following negedge.
   task automatic strobe(input logic [3:0] d);
      @(negedge clk);
      bus.dir_i     = d;
      bus.move_en_i = 1'b1;
      @(negedge clk);
      bus.move_en_i = 1'b0;
   endtask

   task automatic apply(input logic [3:0] d);
      strobe(d);
      strobe(d);
   endtask

   task automatic respawn();
      @(negedge clk);
      bus.respawn_i = 1'b1;
      @(negedge clk);
      bus.respawn_i = 1'b0;
   endtask

`ifdef CRAFT_MOVER_ACCEL_EN
   task automatic astrobe(input logic [3:0] d);
      @(negedge clk);
      abus.dir_i     = d;
      abus.move_en_i = 1'b1;
      @(negedge clk);
      abus.move_en_i = 1'b0;
   endtask
`endif

   initial begin
      bus.move_en_i = 1'b0;
      bus.dir_i     = 4'd0;
      bus.respawn_i = 1'b0;
`ifdef CRAFT_MOVER_ACCEL_EN
      abus.move_en_i = 1'b0;
      abus.dir_i     = 4'd0;
      abus.respawn_i = 1'b0;
`endif
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_pos("reset", 304, 400, 0, 0);

      // Left with prescaler of 2
      strobe(4'b0010);
      check("left s1 x", int'(bus.x_pos_o), 304);
      strobe(4'b0010);
      check("left s2 x", int'(bus.x_pos_o), 302);
      check("left s2 moving", int'(bus.moving_o), 1);
      strobe(4'b0010);
      check("left s3 x", int'(bus.x_pos_o), 302);
      strobe(4'b0010);
      check_pos("left s4", 300, 400, 1, 0);

      // Approach x=604 alternating right with a cancelled x request
      for (int i = 0; i < 152; i++) begin
         apply(4'b0001);
         apply(4'b0011);
      end
      check_pos("approach", 604, 400, 0, 0);
      apply(4'b0001);
      check_pos("right clamp1", 606, 400, 1, 1);
      apply(4'b0001);
      check_pos("right clamp2", 606, 400, 0, 1);
      apply(4'b0001);
      check_pos("right clamp3", 606, 400, 0, 1);

      // Diagonal then cancelled vertical
      respawn();
      check_pos("respawn1", 304, 400, 0, 0);
      apply(4'b1001);
      check_pos("diag", 306, 398, 1, 0);
      apply(4'b1100);
      check_pos("updown", 306, 398, 0, 0);

      // Corner, then respawn colliding with the prescaler wrap
      respawn();
      for (int i = 0; i < 200; i++) apply(4'b1010);
      check_pos("corner", 2, 2, 0, 4'b1010);
      strobe(4'b1010);
      @(negedge clk);
      bus.dir_i     = 4'b1010;
      bus.move_en_i = 1'b1;
      bus.respawn_i = 1'b1;
      @(negedge clk);
      bus.move_en_i = 1'b0;
      bus.respawn_i = 1'b0;
      check_pos("respawn wrap", 304, 400, 0, 0);
      strobe(4'b0010);
      check("post respawn s1 x", int'(bus.x_pos_o), 304);
      strobe(4'b0010);
      check("post respawn s2 x", int'(bus.x_pos_o), 302);

`ifdef CRAFT_MOVER_ACCEL_EN
      check("acc init y", int'(abus.y_pos_o), 300);
      astrobe(4'b0100);
      check("acc s1 y", int'(abus.y_pos_o), 302);
      astrobe(4'b0100);
      check("acc s2 y", int'(abus.y_pos_o), 304);
      astrobe(4'b0100);
      check("acc s3 y", int'(abus.y_pos_o), 306);
      astrobe(4'b0100);
      check("acc s4 y", int'(abus.y_pos_o), 310);
      astrobe(4'b0100);
      check("acc s5 y", int'(abus.y_pos_o), 314);
      astrobe(4'b0000);
      check("acc zero y", int'(abus.y_pos_o), 314);
      check("acc zero moving", int'(abus.moving_o), 0);
      astrobe(4'b0100);
      check("acc resume y", int'(abus.y_pos_o), 316);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/craft_mover.md
Name: craft_mover

Overview:
- Parametrised position engine for a player-controlled craft in the plane-war display pipeline.
- Generalises the single-direction mover:
  - 4-bit direction mask, so diagonal moves are possible;
  - configurable step size and step-rate prescaler;
  - clamped bounds derived from display and sprite size;
  - respawn input;
  - per-edge contact flags.
- Outputs feed the sprite renderer and collision logic.

Parameters:
X_W, 10, width of x coordinate
Y_W, 10, width of y coordinate
H_DISP, 640, visible width in pixels
V_DISP, 480, visible height in pixels
OBJ_X_SIZE, 32, sprite width
OBJ_Y_SIZE, 32, sprite height
MARGIN, 2, guard band at every edge
STEP, 2, pixels moved per applied step (1..MARGIN+OBJ size)
TICK_DIV, 2, move_en_i strobes per applied step (>=1)
DEF_X, 304, reset/respawn x
DEF_Y, 400, reset/respawn y

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
move_en_i  in  1  movement strobe (one cycle, typically per frame)
dir_i  in  4  direction mask {up,down,left,right} = bits [3:0]
respawn_i  in  1  return craft to DEF_X/DEF_Y
x_pos_o  out  X_W  craft left edge
y_pos_o  out  Y_W  craft top edge
moving_o  out  1  last applied step changed position
at_edge_o  out  4  {top,bottom,left,right} contact flags

Behaviour:
- Derived bounds:
  - X_MIN = MARGIN; X_MAX = H_DISP-OBJ_X_SIZE-MARGIN (606).
  - Y_MIN = MARGIN; Y_MAX = V_DISP-OBJ_Y_SIZE-MARGIN (446).
- Reset (clk edge with rst=1): x_pos_o=DEF_X, y_pos_o=DEF_Y, moving_o=0, prescaler=0.
  - at_edge_o is the value computed from DEF_X/DEF_Y (0000 at defaults).
- Priority per cycle: rst > respawn_i > move_en_i.
- Respawn:
  - Positions load the defaults, prescaler clears, moving_o=0.
  - Any move_en_i in the same cycle is ignored.
- Prescaler:
  - Counter of width clog2(TICK_DIV), advanced on each move_en_i.
  - When it equals TICK_DIV-1 while move_en_i=1, it wraps to 0 and a step is applied in that same cycle.
  - TICK_DIV=1 applies a step on every strobe.
- Step evaluation: each axis is evaluated independently.
  - up XOR down selects the y direction; both set or neither set means no y motion. The same rule applies to left/right for x.
  - Decrement: new = (pos-STEP < MIN) ? MIN : pos-STEP. The comparison is done without underflow (pos < MIN+STEP).
  - Increment: new = (pos+STEP > MAX) ? MAX : pos+STEP. Use an internal width of X_W+1 / Y_W+1.
  - A diagonal request moves both axes in the same cycle.
- moving_o:
  - Updates only on applied-step cycles.
  - Set to 1 if x or y changed, otherwise 0 (already clamped, or no/cancelled direction).
  - Holds its value between steps.
- at_edge_o:
  - Registered; updated with the position.
  - top = (y==Y_MIN), bottom = (y==Y_MAX), left = (x==X_MIN), right = (x==X_MAX).
- Latency: position changes one clk after the qualifying move_en_i edge.
- Out-of-range defaults: if DEF_X/DEF_Y lie outside the bounds, the first step clamps them into range. This is documented and is not an error.
- The dir_i value is sampled only in step cycles; dir_i changes between strobes have no effect.

Optional Feature:
- Macro: CRAFT_MOVER_ACCEL_EN.
- Defined:
  - A 2-bit hold counter counts consecutive applied steps that have an identical, non-zero dir_i.
  - When the counter saturates at 3, the step size becomes 2*STEP, with the same clamping rules.
  - A direction change, a zero direction, a respawn or a reset clears the counter, and the step size returns to STEP.
- Undefined: step size is always STEP and no counter logic is synthesised.

Test Plan:
1. Reset with rst=1 for 2 cycles, then release -> x=304, y=400, moving_o=0, at_edge_o=0000.
2. TICK_DIV=2, dir=0010 (left), 4 move_en_i strobes -> x goes 304, then 302 after the 2nd strobe, then 300 after the 4th; moving_o=1; y unchanged.
3. Hold right from x=604, STEP=2, with 3 qualifying steps -> x goes 606, 606, 606; moving_o goes 1, 0, 0; at_edge_o[0]=1 from the first step.
4. Diagonal dir=1001 (up+right) from (304,400) with 1 qualifying step -> (306,398). Then dir=1100 (up+down) -> no change, moving_o=0.
5. respawn_i and move_en_i asserted together at the prescaler wrap, with position (2,2) -> (304,400), prescaler=0, moving_o=0. The next strobe does not step when TICK_DIV=2.
6. With CRAFT_MOVER_ACCEL_EN and TICK_DIV=1, hold down from y=300 for 5 strobes -> y goes 302, 304, 306, 310, 314. Changing to dir=0000 and then back to down for 1 strobe -> y=316.
